// File: rtl/cpu_mem_pkg.sv
// Shared memory-path definitions: store size codes, error codes,
// store FSM states and the request legality check.
package cpu_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_SIZE    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LO   = 2'b01,
        ST_HI   = 2'b10,
        ST_RESP = 2'b11
    } st_t;

    // Illegal size outranks misalignment.
    function automatic logic [1:0] check_req(
        input logic [1:0] size,
        input logic [1:0] addr_lo
    );
        logic [1:0] code;
        code = ERR_NONE;
        unique case (1'b1)
            (size == SZ_ILL):
                code = ERR_SIZE;
            (size == SZ_HALF) && addr_lo[0]:
                code = ERR_ALIGN;
            (size == SZ_WORD) && (addr_lo != 2'b00):
                code = ERR_ALIGN;
            default:
                code = ERR_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/store_beat_format.sv
// Combinational beat formatter: maps a latched store onto one 16-bit beat.
// Ports: i_size/i_addr/i_data/i_hi in; o_addr/o_wdata/o_be out.
module store_beat_format
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [1:0]        i_size,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_data,
    input  logic              i_hi,
    output logic [ADDR_W-1:0] o_addr,
    output logic [15:0]       o_wdata,
    output logic [1:0]        o_be
);

    always_comb begin
        o_addr  = '0;
        o_wdata = '0;
        o_be    = 2'b00;
        unique case (i_size)
            SZ_BYTE: begin
                // Byte replicated on both lanes; the enable picks the lane.
                o_addr  = {i_addr[ADDR_W-1:1], 1'b0};
                o_wdata = {i_data[7:0], i_data[7:0]};
                o_be    = i_addr[0] ? 2'b10 : 2'b01;
            end
            SZ_HALF: begin
                o_addr  = i_addr;
                o_wdata = i_data[15:0];
                o_be    = 2'b11;
            end
            SZ_WORD: begin
                // Little-endian: low half first, high half at addr+2.
                o_addr  = i_hi ? (i_addr + ADDR_W'(2)) : i_addr;
                o_wdata = i_hi ? i_data[31:16] : i_data[15:0];
                o_be    = 2'b11;
            end
            default: begin
                o_addr  = '0;
                o_wdata = '0;
                o_be    = 2'b00;
            end
        endcase
    end

endmodule

// File: rtl/store_narrow_unit.sv
// Narrows 32-bit byte/half/word stores onto a 16-bit write bus.
// Ports: req_* (store in), mem_* (beat out), done/err/err_code pulses.
module store_narrow_unit
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int WAIT_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_be,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    st_t               r_state;
    st_t               w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic [1:0]        r_size;
    logic [CW-1:0]     r_wait;
    logic [1:0]        r_code;
    logic [1:0]        w_code_next;

    logic              w_accept;
    logic [1:0]        w_chk;
    logic              w_beat;
    logic              w_hs;
    logic              w_stall;
    logic              w_wait_last;
    logic              w_tmo;

    logic [ADDR_W-1:0] w_fmt_addr;
    logic [15:0]       w_fmt_wdata;
    logic [1:0]        w_fmt_be;

    assign w_accept    = req_valid && (r_state == ST_IDLE);
    assign w_chk       = check_req(req_size, req_addr[1:0]);
    assign w_beat      = (r_state == ST_LO) || (r_state == ST_HI);
    assign w_hs        = w_beat && mem_ready;
    assign w_stall     = w_beat && !mem_ready;
    assign w_wait_last = (r_wait == CW'(WAIT_MAX - 1));
    // A stall on the last allowed cycle aborts; a handshake there wins.
    assign w_tmo       = w_stall && w_wait_last;

    always_comb begin
        w_next      = r_state;
        w_code_next = r_code;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_code_next = w_chk;
                    w_next = (w_chk == ERR_NONE) ? ST_LO : ST_RESP;
                end
            end
            ST_LO: begin
                if (w_hs) begin
                    w_next = (r_size == SZ_WORD) ? ST_HI : ST_RESP;
                end else if (w_tmo) begin
                    w_next      = ST_RESP;
                    w_code_next = ERR_TIMEOUT;
                end
            end
            ST_HI: begin
                if (w_hs) begin
                    w_next = ST_RESP;
                end else if (w_tmo) begin
                    w_next      = ST_RESP;
                    w_code_next = ERR_TIMEOUT;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_code  <= ERR_NONE;
        end else begin
            r_state <= w_next;
            r_code  <= w_code_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_data <= '0;
            r_size <= SZ_BYTE;
        end else if (w_accept) begin
            r_addr <= req_addr;
            r_data <= req_data;
            r_size <= req_size;
        end
    end

    // Counts consecutive stalled cycles of the current beat only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait <= '0;
        end else if (w_stall && !w_wait_last) begin
            r_wait <= r_wait + CW'(1);
        end else begin
            r_wait <= '0;
        end
    end

    store_beat_format #(
        .ADDR_W (ADDR_W)
    ) u_fmt (
        .i_size  (r_size),
        .i_addr  (r_addr),
        .i_data  (r_data),
        .i_hi    (r_state == ST_HI),
        .o_addr  (w_fmt_addr),
        .o_wdata (w_fmt_wdata),
        .o_be    (w_fmt_be)
    );

    // Outputs decode straight from state so reset clears them at once.
    assign req_ready = (r_state == ST_IDLE);
    assign mem_valid = w_beat;
    assign mem_addr  = w_beat ? w_fmt_addr  : '0;
    assign mem_wdata = w_beat ? w_fmt_wdata : '0;
    assign mem_be    = w_beat ? w_fmt_be    : 2'b00;
    assign done      = (r_state == ST_RESP) && (r_code == ERR_NONE);
    assign err       = (r_state == ST_RESP) && (r_code != ERR_NONE);
    assign err_code  = err ? r_code : ERR_NONE;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Scoreboard bench for store_narrow_unit: random stores with a
// behavioural model, a reactive memory responder and a monitor.
module tb_store_narrow_unit;

    localparam int AW = 32;
    localparam int WM = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_data;
    logic [1:0]    req_size;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic [1:0]    mem_be;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    store_narrow_unit #(.ADDR_W(AW), .WAIT_MAX(WM)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [15:0] d;
        logic [1:0]  be;
    } beat_t;

    beat_t beat_q[$];
    int    resp_q[$];
    int    plan_q[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: what the store should do on the bus, given how many
    // cycles the memory will stall each beat.
    task automatic model(input logic [31:0] addr, input logic [31:0] data,
                         input int size, input int s0, input int s1);
        int    nb;
        int    st[2];
        beat_t b;
        st[0] = s0;
        st[1] = s1;
        if (size == 3) begin
            resp_q.push_back(2);
            return;
        end
        if ((size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0)) begin
            resp_q.push_back(1);
            return;
        end
        nb = (size == 2) ? 2 : 1;
        for (int i = 0; i < nb; i++) begin
            if (size == 0) begin
                b.a  = addr - addr % 2;
                b.d  = (data % 256) * 257;
                b.be = (addr % 2 != 0) ? 2'd2 : 2'd1;
            end else begin
                b.a  = addr + 2 * i;
                b.d  = (i == 0) ? data % 65536 : data / 65536;
                b.be = 2'd3;
            end
            plan_q.push_back(st[i]);
            if (st[i] >= WM) begin
                resp_q.push_back(3);
                return;
            end
            beat_q.push_back(b);
        end
        resp_q.push_back(0);
    endtask

    // Memory: stall each beat for its planned cycle count, then accept.
    int  cur;
    int  seen;
    bit  have;
    initial begin
        mem_ready = 1'b0;
        have = 1'b0;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (rst || !mem_valid) begin
                mem_ready = 1'b0;
                have = 1'b0;
            end else begin
                if (!have) begin
                    cur  = (plan_q.size() > 0) ? plan_q.pop_front() : 0;
                    seen = 0;
                    have = 1'b1;
                end
                mem_ready = (seen >= cur);
                seen++;
                if (mem_ready) have = 1'b0;
            end
        end
    end

    // Monitor
    bit          p_resp;
    bit          p_stall;
    logic [31:0] p_addr;
    logic [15:0] p_wdata;
    logic [1:0]  p_be;
    beat_t       eb;
    int          er;

    always @(negedge clk) begin
        if (rst) begin
            p_resp  = 1'b0;
            p_stall = 1'b0;
        end else begin
            if (p_resp) check("req_ready_after_resp", req_ready, 1);
            if (!mem_valid) check("idle_bus", {mem_be, mem_wdata}, 0);
            if (mem_valid && p_stall) begin
                check("stable_addr", mem_addr, p_addr);
                check("stable_wdata", mem_wdata, p_wdata);
                check("stable_be", mem_be, p_be);
            end
            if (mem_valid && mem_ready) begin
                if (beat_q.size() == 0) begin
                    check("unexpected_beat", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    eb = beat_q.pop_front();
                    check("beat_addr", mem_addr, eb.a);
                    check("beat_wdata", mem_wdata, eb.d);
                    check("beat_be", mem_be, eb.be);
                end
            end
            if (done || err) begin
                check("done_err_excl", done & err, 0);
                if (resp_q.size() == 0) begin
                    check("unexpected_resp", {done, err, err_code}, 0);
                end else begin
                    er = resp_q.pop_front();
                    check("resp_err", err, er != 0);
                    check("resp_code", err_code, er);
                end
            end
            p_resp  = done || err;
            p_stall = mem_valid && !mem_ready;
            p_addr  = mem_addr;
            p_wdata = mem_wdata;
            p_be    = mem_be;
        end
    end

    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input int sz, input int s0, input int s1);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("req_ready_wait", 0, 1);
            return;
        end
        model(a, d, sz, s0, s1);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = 2'(sz);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
        req_size  = 2'($urandom_range(0, 3));
    endtask

    function automatic int rnd_stall();
        int r = $urandom_range(0, 19);
        if (r < 12) return 0;
        if (r < 17) return $urandom_range(1, 4);
        return $urandom_range(WM - 1, WM + 2);
    endfunction

    initial begin
        int          sz;
        logic [31:0] a;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_size  = 2'b00;
        #12;
        check("rst_req_ready", req_ready, 1);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        @(negedge clk);
        rst = 1'b0;

        do_store(32'h0000_1000, 32'hDEAD_BEEF, 2, 0, 0);

        // One-beat latency: beat at T+1, done at T+2, ready at T+3.
        do_store(32'h0000_2003, 32'h0000_00A5, 0, 0, 0);
        check("t1_mem_valid", mem_valid, 1);
        @(posedge clk); #1;
        check("t2_done", done, 1);
        @(posedge clk); #1;
        check("t3_req_ready", req_ready, 1);

        do_store(32'h0000_2002, 32'h0000_00A5, 0, 0, 0);
        do_store(32'h0000_3001, 32'h1234_5678, 1, 0, 0);
        do_store(32'h0000_3000, 32'h1234_5678, 1, 0, 0);
        do_store(32'h0000_5557, 32'h1111_2222, 3, 0, 0);
        do_store(32'h0000_1002, 32'h3333_4444, 2, 0, 0);
        do_store(32'h0000_6000, 32'hCAFE_F00D, 2, 3, 0);
        do_store(32'h0000_7000, 32'h0BAD_BEEF, 2, WM, 0);
        do_store(32'h0000_7100, 32'h0BAD_BEEF, 2, 0, WM);
        do_store(32'h0000_7201, 32'h0000_0077, 0, WM - 1, 0);

        // Reset in the middle of a stalled high beat.
        do_store(32'h0000_4000, 32'h8765_4321, 2, 0, 20);
        @(posedge clk); #2;
        check("hi_beat_addr", mem_addr, 32'h0000_4002);
        rst = 1'b1;
        #1;
        check("rst_mid_mem_valid", mem_valid, 0);
        beat_q.delete();
        resp_q.delete();
        plan_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_req_ready", req_ready, 1);
        do_store(32'h0000_4000, 32'h8765_4321, 2, 0, 1);

        for (int i = 0; i < 150; i++) begin
            int r = $urandom_range(0, 7);
            sz = (r < 2) ? 0 : (r < 4) ? 1 : (r < 7) ? 2 : 3;
            a  = $urandom;
            if ($urandom_range(0, 9) < 7) a = a - a % 4;
            do_store(a, $urandom, sz, rnd_stall(), rnd_stall());
        end

        repeat (60) @(negedge clk);
        check("beats_left", beat_q.size(), 0);
        check("resps_left", resp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
